// File: rtl/operand_capture_register_if.sv
// Handshake and bus bundle for operand_capture_register: fill-side input, direct
// write port, and the presented operand set.
interface operand_capture_register_if #(
  parameter int WIDTH = 16,
  parameter int COUNT = 3,
  parameter int IDXW  = $clog2(COUNT)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   wr_en;
  logic [IDXW-1:0]        wr_idx;
  logic [WIDTH-1:0]       wr_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [COUNT*WIDTH-1:0] out_data;
  logic [IDXW-1:0]        fill_idx;

  modport master (
    output in_valid, in_data, wr_en, wr_idx, wr_data, out_ready,
    input  in_ready, out_valid, out_data, fill_idx
  );

  modport slave (
    input  in_valid, in_data, wr_en, wr_idx, wr_data, out_ready,
    output in_ready, out_valid, out_data, fill_idx
  );
endinterface

// File: rtl/operand_capture_register.sv
// Collects COUNT words (e.g. SUBLEQ A/B/C operands) into slots, presents the full
// set until taken, and allows direct overwrite of any slot at any time.
module operand_capture_register #(
  parameter int WIDTH = 16,
  parameter int COUNT = 3,
  parameter int IDXW  = $clog2(COUNT)
) (
  input logic clk,
  input logic areset,
  input logic clear,
  operand_capture_register_if.slave bus
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(COUNT - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t           state, state_nxt;
  logic [IDXW-1:0]  fill_idx;
  logic [WIDTH-1:0] slot [COUNT];
  logic             capture;

  assign capture = bus.in_valid && (state == FILL);

  always_ff @(posedge clk) begin
    if (areset || clear) state <= FILL;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: if (capture && (fill_idx == LAST_IDX)) state_nxt = FULL;
      FULL: if (bus.out_ready)                     state_nxt = FILL;
      default:                                     state_nxt = FILL;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == FILL);
    bus.out_valid = (state == FULL);
  end

  always_ff @(posedge clk) begin
    if (areset || clear) begin
      fill_idx <= '0;
    end else if (capture) begin
      fill_idx <= (fill_idx == LAST_IDX) ? '0 : fill_idx + IDXW'(1);
    end
  end

  // Direct write is evaluated after capture so it wins on a shared slot;
  // out-of-range wr_idx matches no slot and is dropped.
  always_ff @(posedge clk) begin
    if (areset || clear) begin
      for (int unsigned k = 0; k < COUNT; k++) slot[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < COUNT; k++) begin
        if (capture && (fill_idx == IDXW'(k)))     slot[k] <= bus.in_data;
        if (bus.wr_en && (bus.wr_idx == IDXW'(k))) slot[k] <= bus.wr_data;
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int unsigned k = 0; k < COUNT; k++) bus.out_data[k*WIDTH +: WIDTH] = slot[k];
    bus.fill_idx = fill_idx;
  end

endmodule

// File: tb/tb_operand_capture_register.sv
// Directed and randomized checks of operand_capture_register against a
// set-level reference model.
module tb_operand_capture_register;
  localparam int WIDTH = 16;
  localparam int COUNT = 3;
  localparam int IDXW  = 2;

  logic clk = 1'b0;
  logic areset, clear;
  always #5 clk = ~clk;

  operand_capture_register_if #(.WIDTH(WIDTH), .COUNT(COUNT), .IDXW(IDXW)) bus ();
  operand_capture_register #(.WIDTH(WIDTH), .COUNT(COUNT), .IDXW(IDXW)) dut (
    .clk(clk), .areset(areset), .clear(clear), .bus(bus.slave)
  );

  // Reference model: slot contents, words gathered so far in this set, and whether a set is pending.
  logic [WIDTH-1:0] m_slot [COUNT];
  int               m_n;
  bit               m_full;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit pre_acc, pre_take;
  logic [COUNT*WIDTH-1:0] pre_data, saved;
  logic [COUNT*WIDTH-1:0] take_q [$];
  int take_cyc [$];
  logic [WIDTH-1:0] w [9];
  int ptr;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COUNT*WIDTH-1:0] model_data();
    logic [COUNT*WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < COUNT; k++) d[k*WIDTH +: WIDTH] = m_slot[k];
    return d;
  endfunction

  task automatic model_edge();
    bit cap, take;
    if (areset || clear) begin
      for (int k = 0; k < COUNT; k++) m_slot[k] = '0;
      m_n = 0;
      m_full = 0;
    end else begin
      cap  = !m_full && bus.in_valid;
      take = m_full && bus.out_ready;
      if (cap) begin
        m_slot[m_n] = bus.in_data;
        m_n++;
        if (m_n == COUNT) begin
          m_n = 0;
          m_full = 1;
        end
      end else if (take) begin
        m_full = 0;
      end
      if (bus.wr_en && int'(bus.wr_idx) < COUNT) m_slot[bus.wr_idx] = bus.wr_data;
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".in_ready"},  bus.in_ready,  !m_full);
    check({tag, ".out_valid"}, bus.out_valid, m_full);
    check({tag, ".fill_idx"},  bus.fill_idx,  m_n);
    check({tag, ".out_data"},  bus.out_data,  model_data());
  endtask

  task automatic step(string tag);
    pre_acc  = bus.in_valid && bus.in_ready;
    pre_take = bus.out_valid && bus.out_ready;
    pre_data = bus.out_data;
    @(posedge clk);
    model_edge();
    cyc++;
    if (pre_take) begin
      take_q.push_back(pre_data);
      take_cyc.push_back(cyc);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int k = 0; k < COUNT; k++) m_slot[k] = '0;
    m_n = 0; m_full = 0;
    areset = 1'b1; clear = 1'b0;
    bus.in_valid = 0; bus.in_data = '0; bus.wr_en = 0; bus.wr_idx = '0;
    bus.wr_data = '0; bus.out_ready = 0;

    // Reset state
    step("reset"); step("reset");
    areset = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);

    // Three words fill a set; out_valid the cycle after the third
    bus.in_valid = 1; bus.in_data = 16'h0011; step("fill0");
    check("fill0_out_valid", bus.out_valid, 0);
    bus.in_data = 16'h0022; step("fill1");
    bus.in_data = 16'h0033; step("fill2");
    bus.in_valid = 0;
    check("full_out_valid", bus.out_valid, 1);
    check("full_in_ready", bus.in_ready, 0);
    check("full_out_data", bus.out_data, 48'h0033_0022_0011);

    // FULL holds against in_valid until taken
    bus.in_valid = 1; bus.in_data = 16'hFFFF; bus.out_ready = 0;
    repeat (5) step("hold");
    check("hold_out_data", bus.out_data, 48'h0033_0022_0011);
    check("hold_fill_idx", bus.fill_idx, 0);
    bus.in_valid = 0; bus.out_ready = 1; step("take");
    bus.out_ready = 0;
    check("take_in_ready", bus.in_ready, 1);
    check("take_retained", bus.out_data, 48'h0033_0022_0011);

    // Direct write collides with capture on slot 1
    bus.in_valid = 1; bus.in_data = 16'h0101; step("pre_wr");
    bus.in_data = 16'h1234; bus.wr_en = 1; bus.wr_idx = 2'd1; bus.wr_data = 16'hBEEF;
    step("collide");
    bus.in_valid = 0; bus.wr_en = 0;
    check("collide_slot1", bus.out_data[31:16], 16'hBEEF);
    check("collide_fill_idx", bus.fill_idx, 2);

    // Out-of-range direct write is ignored
    saved = bus.out_data;
    bus.wr_en = 1; bus.wr_idx = 2'd3; bus.wr_data = 16'hAAAA; step("oor");
    bus.wr_en = 0;
    check("oor_data", bus.out_data, saved);
    check("oor_fill_idx", bus.fill_idx, 2);
    check("oor_in_ready", bus.in_ready, 1);

    // clear mid-fill, concurrent with a word
    clear = 1; bus.in_valid = 1; bus.in_data = 16'h5555; step("clear");
    clear = 0; bus.in_valid = 0;
    check("clear_data", bus.out_data, 0);
    check("clear_fill_idx", bus.fill_idx, 0);
    bus.in_valid = 1; bus.in_data = 16'h0A0A; step("refill0");
    bus.in_data = 16'h0B0B; step("refill1");
    areset = 1; bus.in_data = 16'h6666; step("areset");
    areset = 0; bus.in_valid = 0;
    check("areset_data", bus.out_data, 0);
    check("areset_fill_idx", bus.fill_idx, 0);
    check("areset_in_ready", bus.in_ready, 1);

    // Back-to-back throughput with 9 distinct words
    for (int i = 0; i < 9; i++) w[i] = 16'hC000 + 16'(i * 16'h0111);
    take_q.delete(); take_cyc.delete();
    ptr = 0; bus.in_valid = 1; bus.out_ready = 1; bus.in_data = w[0];
    for (int t = 0; t < 40 && take_q.size() < 3; t++) begin
      step("b2b");
      if (pre_acc) ptr++;
      if (ptr >= 9) bus.in_valid = 0;
      else          bus.in_data = w[ptr];
    end
    bus.in_valid = 0; bus.out_ready = 0;
    check("b2b_sets", take_q.size(), 3);
    if (take_q.size() == 3) begin
      for (int s = 0; s < 3; s++)
        check("b2b_set_data", take_q[s], {w[3*s+2], w[3*s+1], w[3*s]});
      check("b2b_spacing01", take_cyc[1] - take_cyc[0], 4);
      check("b2b_spacing12", take_cyc[2] - take_cyc[1], 4);
    end

    // Randomized traffic against the model
    for (int t = 0; t < 400; t++) begin
      areset        = ($urandom_range(0, 59) == 0);
      clear         = ($urandom_range(0, 39) == 0);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 16'($urandom);
      bus.wr_en     = ($urandom_range(0, 3) == 0);
      bus.wr_idx    = 2'($urandom_range(0, 3));
      bus.wr_data   = 16'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
